obstacle_scroller: RTL



---
 rtl/obstacle_scroller.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/obstacle_scroller.sv
// obstacle_scroller: obstacle slots for the dino game; spawns at the right edge and scrolls left once per frame.
// Optional build macro OBS_SPEED_RAMP_EN adds a speed bonus that grows with every 8th passed obstacle.
module obstacle_scroller #(
    parameter int NUM_OBS = 2,
    parameter int X_W     = 9,
    parameter int SPAWN_X = 319,
    parameter int MIN_GAP = 40,
    parameter int MAX_GAP = 120
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   frame_tick,
    input  logic                   run,
    input  logic                   hit,
    input  logic                   game_reset,
    input  logic [2:0]             speed,
    output logic [NUM_OBS*X_W-1:0] obs_x,
    output logic [NUM_OBS-1:0]     obs_valid,
    output logic [NUM_OBS-1:0]     obs_type,
    output logic                   spawn_pulse,
    output logic                   pass_pulse,
    output logic [1:0]             state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_e;

    state_e                      state_q;
    logic [7:0]                  lfsr_q, lfsr_d;
    logic [7:0]                  gap_q, gap_d;
    logic [NUM_OBS-1:0][X_W-1:0] x_q, x_d;
    logic [NUM_OBS-1:0]          valid_q, valid_d;
    logic [NUM_OBS-1:0]          type_q, type_d;
    logic                        spawn_q, spawn_d;
    logic                        pass_q, pass_d;
    logic [NUM_OBS-1:0]          spawn_oh;
    logic                        free_found;
    logic                        move_en;
    logic [2:0]                  eff_speed;

`ifdef OBS_SPEED_RAMP_EN
    logic [2:0] pass_cnt_q;
    logic [1:0] bonus_q;
    logic [3:0] speed_sum;

    assign speed_sum = {1'b0, speed} + {2'b00, bonus_q};
    assign eff_speed = speed_sum[3] ? 3'd7 : speed_sum[2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt_q <= '0;
            bonus_q    <= '0;
        end else if (game_reset) begin
            pass_cnt_q <= '0;
            bonus_q    <= '0;
        end else if (pass_d) begin
            pass_cnt_q <= pass_cnt_q + 3'd1;
            if (pass_cnt_q == 3'd7 && bonus_q != 2'd3) begin
                bonus_q <= bonus_q + 2'd1;
            end
        end
    end
`else
    assign eff_speed = speed;
`endif

    // Fibonacci taps 8,6,5,4; seed 0xA5 can never reach the all-zero lockup state.
    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    // A hit on a tick edge halts the game instead of moving; leaving RUN never moves.
    assign move_en = (state_q == RUN) && frame_tick && run && !hit && !game_reset;

    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        spawn_oh   = '0;
        free_found = 1'b0;
        x_d        = x_q;
        valid_d    = valid_q;
        type_d     = type_q;
        pass_d     = 1'b0;
        gap_d      = gap_q;

        for (int i = 0; i < NUM_OBS; i++) begin
            if (!valid_q[i] && !free_found) begin
                spawn_oh[i] = 1'b1;
                free_found  = 1'b1;
            end
        end

        spawn_d = move_en && free_found && (gap_q >= 8'(MIN_GAP)) &&
                  ((lfsr_q[1:0] == 2'b00) || (gap_q == 8'(MAX_GAP)));

        for (int i = 0; i < NUM_OBS; i++) begin
            if (spawn_d && spawn_oh[i]) begin
                x_d[i]     = X_W'(SPAWN_X);
                type_d[i]  = lfsr_q[2];
                valid_d[i] = 1'b1;
            end else if (move_en && valid_q[i]) begin
                if (x_q[i] < X_W'(eff_speed)) begin
                    valid_d[i] = 1'b0;
                    pass_d     = 1'b1;
                end else begin
                    x_d[i] = x_q[i] - X_W'(eff_speed);
                end
            end
        end

        if (move_en) begin
            if (spawn_d) begin
                gap_d = '0;
            end else if (gap_q < 8'(MAX_GAP)) begin
                gap_d = gap_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lfsr_q  <= 8'hA5;
            gap_q   <= '0;
            x_q     <= '0;
            valid_q <= '0;
            type_q  <= '0;
            spawn_q <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            lfsr_q  <= lfsr_d;
            spawn_q <= spawn_d;
            pass_q  <= pass_d;
            if (game_reset) begin
                state_q <= IDLE;
                gap_q   <= '0;
                x_q     <= '0;
                valid_q <= '0;
                type_q  <= '0;
            end else begin
                gap_q   <= gap_d;
                x_q     <= x_d;
                valid_q <= valid_d;
                type_q  <= type_d;
                case (state_q)
                    IDLE:    if (run) state_q <= RUN;
                    RUN: begin
                        if (hit) begin
                            state_q <= HALT;
                        end else if (!run) begin
                            state_q <= IDLE;
                        end
                    end
                    HALT:    state_q <= HALT;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign obs_x       = x_q;
    assign obs_valid   = valid_q;
    assign obs_type    = type_q;
    assign spawn_pulse = spawn_q;
    assign pass_pulse  = pass_q;
    assign state       = state_q;

endmodule
